uart_preload_ctrl: RTL

// - Frame parser/sequencer between the UART byte receiver and the PE preload buffer.
// - Consumes the receiver's 1-cycle byte strobe and assembles framed bytes into 32-bit words.
// - Writes the words to the preload buffer, then reports frame done or error to the PE/NICE side.
// - Frame format: 0xA5 | ADDR | LEN | LEN*4 data bytes (little-endian per word) | [CSUM].

---
 rtl/uart_preload_ctrl.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_preload_ctrl.sv
// -----------------------------------------------------------------------------
// uart_preload_ctrl
//
// Frame parser and sequencer that sits between the UART byte receiver and the
// PE preload buffer. It takes the receiver's one-cycle byte strobe and parses
// frames of the form
//     SYNC | ADDR | LEN | LEN*4 data bytes (little-endian per word) | [CSUM]
// It packs the data bytes into 32-bit words, writes them to the buffer, and
// then reports either frame_done or frame_err to the PE/NICE side.
//
// Optional feature:
//     UART_PRELOAD_CSUM_EN. When defined, a trailing checksum byte must match
//     the running XOR of ADDR, LEN and all data bytes.
//
// Parameters:
//     ADDR_W       buffer word-address width (1..8), DEPTH = 2**ADDR_W
//     TIMEOUT_CYC  max idle cycles between bytes inside a frame
//     SYNC_BYTE    frame start marker
//
// Ports:
//     clk          clock, rising edge
//     rst_n        asynchronous active-low reset
//     rx_valid     one-cycle strobe, rx_data holds a new byte
//     rx_data      received byte
//     pe_busy      PE owns the buffer; new frames are refused (sampled in IDLE)
//     buf_wr_en    buffer write strobe, one cycle
//     buf_wr_addr  buffer word address
//     buf_wr_data  buffer word
//     frame_done   one-cycle pulse, frame accepted
//     frame_err    one-cycle pulse, frame aborted
//     err_code     01 timeout, 10 bad LEN/range, 11 checksum; held until next error
//     busy         high whenever the parser is not in IDLE
// -----------------------------------------------------------------------------
module uart_preload_ctrl #(
    parameter int          ADDR_W      = 6,
    parameter int          TIMEOUT_CYC = 1000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              pe_busy,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [31:0]       buf_wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base;
    logic [7:0]        len;
    logic [7:0]        word_idx;
    logic [1:0]        byte_idx;
    logic [23:0]       shift;
    logic [TW-1:0]     tcnt;

    logic              timeout_hit;
    logic              len_bad;
    logic              last_byte;
    logic              last_word;
    logic [9:0]        span;
    logic              csum_ok;

    logic              done_set;
    logic              err_set;
    logic [1:0]        err_val;
    logic              wr_set;

`ifdef UART_PRELOAD_CSUM_EN
    logic [7:0]        csum_acc;
`endif

    // The DONE state is a one-cycle bookkeeping state, so the timer is
    // ignored there; any byte arriving in the same cycle as the timeout
    // expiry wins and keeps the frame alive.
    assign timeout_hit = (state != S_IDLE) && (state != S_DONE) && !rx_valid &&
                         (tcnt == TW'(TIMEOUT_CYC - 1));

    // Span is computed wide enough that base+LEN cannot overflow before the
    // comparison against DEPTH; equality with DEPTH is legal (no wrap needed).
    assign span      = 10'(base) + 10'(rx_data);
    assign len_bad   = (rx_data == 8'd0) || (span > 10'(DEPTH));
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (word_idx == (len - 8'd1));

`ifdef UART_PRELOAD_CSUM_EN
    assign csum_ok = (rx_data == csum_acc);
`else
    assign csum_ok = 1'b1;
`endif

    assign busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A timeout aborts from any in-frame state; otherwise
    // the parser advances only on a received byte.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE) && !pe_busy) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    state_nxt = S_LEN;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    state_nxt = len_bad ? S_IDLE : S_DATA;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (last_byte && last_word) begin
`ifdef UART_PRELOAD_CSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    state_nxt = csum_ok ? S_DONE : S_IDLE;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode. These are the values the registered outputs take on
    // the next edge, so every pulse appears one cycle after its cause and
    // the parser is already back in IDLE while frame_done/frame_err is high.
    always_comb begin
        done_set = 1'b0;
        err_set  = 1'b0;
        err_val  = ERR_TIMEOUT;
        wr_set   = 1'b0;
        if (timeout_hit) begin
            err_set = 1'b1;
            err_val = ERR_TIMEOUT;
        end else begin
            case (state)
                S_LEN: begin
                    if (rx_valid && len_bad) begin
                        err_set = 1'b1;
                        err_val = ERR_RANGE;
                    end
                end
                S_DATA: begin
                    wr_set = rx_valid && last_byte;
                end
                S_CSUM: begin
                    if (rx_valid && !csum_ok) begin
                        err_set = 1'b1;
                        err_val = ERR_CSUM;
                    end
                end
                S_DONE: begin
                    done_set = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath: frame fields, byte assembly, buffer write port, pulses and
    // the inter-byte timer. The timer is held at zero in IDLE and restarts
    // on every byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base        <= '0;
            len         <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            shift       <= '0;
            tcnt        <= '0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= '0;
        end else begin
            buf_wr_en  <= wr_set;
            frame_done <= done_set;
            frame_err  <= err_set;
            if (err_set) begin
                err_code <= err_val;
            end

            if ((state == S_IDLE) || rx_valid) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end

            if (rx_valid) begin
                case (state)
                    S_ADDR: begin
                        base <= rx_data[ADDR_W-1:0];
                    end
                    S_LEN: begin
                        len      <= rx_data;
                        word_idx <= '0;
                        byte_idx <= '0;
                    end
                    S_DATA: begin
                        shift    <= {rx_data, shift[23:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            buf_wr_addr <= base + word_idx[ADDR_W-1:0];
                            buf_wr_data <= {rx_data, shift};
                            word_idx    <= word_idx + 8'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef UART_PRELOAD_CSUM_EN
    // Running XOR starts with the ADDR byte and folds in LEN and every data
    // byte; the checksum byte itself is compared, not accumulated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_acc <= '0;
        end else if (rx_valid) begin
            case (state)
                S_ADDR:       csum_acc <= rx_data;
                S_LEN, S_DATA: csum_acc <= csum_acc ^ rx_data;
                default:      csum_acc <= csum_acc;
            endcase
        end
    end
`endif

endmodule
